// File: rtl/ram_n_pkg.sv
// Shared Hack definitions used by the RAM banks: word width and the
// two-state sweep/run encoding.
package hack_pkg;

  localparam int HACK_WORD_W = 16;

  typedef enum logic [0:0] {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_n_if.sv
// Access bus of a ram_n bank: write data/enable, address, clear request
// from the memory-map side; read data and ready flag back from the bank.
interface ram_n_if #(
  parameter int WIDTH = hack_pkg::HACK_WORD_W,
  parameter int DEPTH = 8
) ();

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic              clr;
  logic [WIDTH-1:0]  out;
  logic              ready;

  modport master (
    output in, load, address, clr,
    input  out, ready
  );

  modport slave (
    input  in, load, address, clr,
    output out, ready
  );

endinterface

// File: rtl/ram_n_register.sv
// Hack register: WIDTH-bit word that captures `in` on a clock edge when
// `load` is high and otherwise holds. No reset; contents are set by the sweep.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_q;

  // Word storage: capture on load, otherwise hold.
  always_ff @(posedge clk) begin
    if (load) begin
      r_q <= in;
    end else begin
      r_q <= r_q;
    end
  end

  assign out = r_q;

endmodule

// File: rtl/ram_n.sv
// Parametrised Hack RAM bank: DEPTH words of WIDTH bits, combinational read,
// synchronous write, with a zeroing sweep after reset or a clr request.
module ram_n
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W,
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  ram_n_if.slave   bus
);

  localparam int                ADDR_W  = $clog2(DEPTH);
  localparam logic [0:0]        ST_INIT = RAM_INIT;
  localparam logic [0:0]        ST_RUN  = RAM_RUN;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ready;
  logic              w_run;
  logic [DEPTH-1:0]  w_load;
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  w_word [DEPTH];
  logic [WIDTH-1:0]  w_out;

  // Sweep/run sequencing; ptr wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (r_ptr == LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.clr) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_ptr   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_wdata = w_run ? bus.in : '0;

  // rst blocks every word write so reset never disturbs array contents.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign w_load[i] = !rst &
                       ((w_run & bus.load & !bus.clr & (bus.address == ADDR_W'(i))) |
                        (!w_run & (r_ptr == ADDR_W'(i))));

    register #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .load (w_load[i]),
      .in   (w_wdata),
      .out  (w_word[i])
    );
  end

  // Read mux, forced to zero until the sweep has finished.
  always_comb begin
    w_out = '0;
    if (r_ready) begin
      w_out = w_word[bus.address];
    end else begin
      w_out = '0;
    end
  end

  assign bus.out   = w_out;
  assign bus.ready = r_ready;

endmodule

// File: tb/tb_ram_n.sv
// Self-checking bench for ram_n: an 8x16 bank against a behavioural model,
// plus a directed check of the 2x1 parameter corner.
module tb_ram_n;

  logic clk;
  logic rst8;
  logic rst2;
  int   n_tests;
  int   n_fail;

  ram_n_if #(.WIDTH(16), .DEPTH(8)) bus8 ();
  ram_n_if #(.WIDTH(1),  .DEPTH(2)) bus2 ();

  ram_n #(.WIDTH(16), .DEPTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));
  ram_n #(.WIDTH(1),  .DEPTH(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Model: memory image plus the number of rst-low edges still needed to finish the sweep.
  logic [15:0] m_mem [8];
  int          m_left;

  function automatic logic [15:0] m_out(input logic [2:0] a);
    return (m_left == 0) ? m_mem[a] : 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step8(input logic r, input logic ld, input logic cl,
                       input logic [2:0] a, input logic [15:0] d);
    rst8 = r; bus8.load = ld; bus8.clr = cl; bus8.address = a; bus8.in = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_left = 8;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int k = 0; k < 8; k++) m_mem[k] = 16'h0000;
    end else if (cl) begin
      m_left = 8;
    end else if (ld) begin
      m_mem[a] = d;
    end
    check("ready8", {15'd0, bus8.ready}, {15'd0, m_left == 0});
    check("out8_after_edge", bus8.out, m_out(a));
  endtask

  task automatic read8(input logic [2:0] a);
    bus8.load = 1'b0; bus8.clr = 1'b0; bus8.address = a;
    #1;
    check("read8", bus8.out, m_out(a));
  endtask

  task automatic read8_all();
    for (int k = 0; k < 8; k++) read8(3'(k));
  endtask

  task automatic step2(input logic r, input logic ld, input logic a, input logic d);
    rst2 = r; bus2.load = ld; bus2.clr = 1'b0; bus2.address = a; bus2.in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_left  = 8;
    for (int k = 0; k < 8; k++) m_mem[k] = 16'hxxxx;
    rst8 = 1'b1; bus8.load = 1'b0; bus8.clr = 1'b0; bus8.address = 3'd0; bus8.in = 16'h0;
    rst2 = 1'b1; bus2.load = 1'b0; bus2.clr = 1'b0; bus2.address = 1'b0; bus2.in = 1'b0;

    // Reset held two edges; out must be zero everywhere.
    step8(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    step8(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    check("reset_ready", {15'd0, bus8.ready}, 16'h0000);
    read8_all();

    // Sweep, with a load to addr 0 that must be ignored.
    step8(1'b0, 1'b1, 1'b0, 3'd0, 16'h5555);
    for (int k = 0; k < 5; k++) step8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("sweep_ready_edge7", {15'd0, bus8.ready}, 16'h0000);
    step8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("sweep_ready_edge8", {15'd0, bus8.ready}, 16'h0001);
    read8_all();

    // Write with read-before-edge showing the old word.
    bus8.load = 1'b1; bus8.address = 3'd3; bus8.in = 16'hBEEF;
    #1;
    check("rdw_old", bus8.out, 16'h0000);
    step8(1'b0, 1'b1, 1'b0, 3'd3, 16'hBEEF);
    check("wr_beef", bus8.out, 16'hBEEF);
    step8(1'b0, 1'b1, 1'b0, 3'd7, 16'h1234);
    check("wr_1234", bus8.out, 16'h1234);
    read8_all();

    // clr beats load; ready returns 8 edges later.
    step8(1'b0, 1'b1, 1'b1, 3'd2, 16'hAAAA);
    check("clr_drop", {15'd0, bus8.ready}, 16'h0000);
    for (int k = 0; k < 8; k++) step8(1'b0, 1'b0, 1'b0, 3'd2, 16'h0);
    check("clr_back", {15'd0, bus8.ready}, 16'h0001);
    read8(3'd2);
    read8(3'd3);
    check("clr_addr3", bus8.out, 16'h0000);

    // Reset in the middle of a sweep restarts it.
    step8(1'b0, 1'b1, 1'b0, 3'd5, 16'h7777);
    step8(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    for (int k = 0; k < 3; k++) step8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step8(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int k = 0; k < 7; k++) step8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("midrst_edge7", {15'd0, bus8.ready}, 16'h0000);
    step8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("midrst_edge8", {15'd0, bus8.ready}, 16'h0001);
    read8_all();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step8(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
      read8(3'($urandom_range(0, 7)));
    end

    // WIDTH=1, DEPTH=2 corner.
    step2(1'b1, 1'b0, 1'b0, 1'b0);
    check("w1_reset_ready", {15'd0, bus2.ready}, 16'h0000);
    check("w1_reset_out", {15'd0, bus2.out}, 16'h0000);
    step2(1'b0, 1'b1, 1'b0, 1'b1);
    check("w1_sweep1", {15'd0, bus2.ready}, 16'h0000);
    step2(1'b0, 1'b0, 1'b0, 1'b0);
    check("w1_sweep2", {15'd0, bus2.ready}, 16'h0001);
    step2(1'b0, 1'b1, 1'b1, 1'b1);
    check("w1_addr1", {15'd0, bus2.out}, 16'h0001);
    bus2.load = 1'b0; bus2.address = 1'b0;
    #1;
    check("w1_addr0", {15'd0, bus2.out}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_n.md
# ram_n

Parametrised Hack RAM: DEPTH words of WIDTH bits, with a combinational read port and a synchronous write port. It generalises the fixed RAM8/RAM64 chips of the Hack memory hierarchy. It adds a hardware clear sweep that zeroes every word after reset or on request, and a `ready` flag that tells the CPU/memory-map logic when the array may be used. It sits under the Hack data-memory map, one instance per RAM bank.

## Interface
Parameters:
- WIDTH, 16, bits per word; must be ≥ 1
- DEPTH, 8, number of words; must be a power of two ≥ 2
- ADDR_W (localparam), $clog2(DEPTH), address width

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset; synchronous and active-high
- in  input  WIDTH  write data
- load  input  1  write enable; samples `in` into mem[address] at the next edge
- address  input  ADDR_W  read/write address
- clr  input  1  single-cycle request to re-zero the whole array
- out  output  WIDTH  read data, combinational from mem[address]
- ready  output  1  registered; high when the array is in RUN state

## Operation
- FSM has two states. INIT sweeps the array to zero. RUN provides normal access.
- **rst high at an edge:**
  - state ← INIT, sweep pointer ptr ← 0, ready ← 0.
  - Memory contents are not touched on that edge.
- **INIT, each edge:**
  - mem[ptr] ← 0 and ptr ← ptr + 1.
  - On the edge where ptr == DEPTH-1, state ← RUN, ptr wraps to 0, ready ← 1.
  - load and clr are ignored; no write occurs.
- **RUN, each edge:**
  - If clr is high: state ← INIT, ptr ← 0, ready ← 0. Any simultaneous load is dropped, so clr wins.
  - Else if load is high: mem[address] ← in.
  - Else: hold.
- **Read:**
  - out = mem[address] when ready is high.
  - out = 0 while ready is low, including during reset and INIT.
  - out follows address combinationally, with no latency.
- **Read-during-write:** out shows the old word until the edge and the new word after it (Hack register semantics).
- **rst mid-sweep:** the sweep restarts at ptr 0. Words already cleared stay zero.
- **rst overrides clr and load** in every state.
- address is always in range because DEPTH is a power of two, so there is no out-of-range case.

## Timing
- Reset values: ready = 0 and out = 0. Memory is undefined until the sweep completes.
- Sweep length is exactly DEPTH edges, counted from the first edge with rst low. ready rises on the DEPTH-th such edge.
- **Sweep timing for a clr request:**
  - A clr sampled high in RUN drops ready at that same edge.
  - ready returns high DEPTH edges later.
  - The array is unavailable for DEPTH+1 edges in total, counting the clr edge.
- Write latency is 1 edge. A read of the written address reflects the new data immediately after that edge.
- Read latency is 0, since out is combinational.
- ready is a flop output and is glitch-free.

## Structure
- Shared package `hack_pkg`:
  - constant HACK_WORD_W = 16
  - typedef `ram_state_t` enum {RAM_INIT, RAM_RUN}
- Sub-module `register`: a parametrised WIDTH-bit Hack register with inputs clk, rst-free load, and in, and output out.
  - ram_n instantiates DEPTH of these in a generate loop.
  - Per-word load = (state==RUN & load & !clr & address==i) | (state==INIT & ptr==i).
  - Per-word data is 0 in INIT and in otherwise.
- Read path is a DEPTH:1 mux on address, gated by ready.

## Test plan
- **Reset sweep, DEPTH=8:**
  - Stimulus: hold rst for 2 edges, then release.
  - Required: ready=0 for the next 7 edges, ready=1 after the 8th edge, out=0 at all 8 addresses.
- **Write/read, WIDTH=16:**
  - Stimulus: write 0xBEEF to addr 3 and 0x1234 to addr 7 with load pulses.
  - Required: before the edge, addr 3 reads 0x0000; after it, addr 3 reads 0xBEEF and addr 7 reads 0x1234. Other addresses read 0.
- **clr vs load:**
  - Stimulus: in RUN, assert clr=1 and load=1 (addr 2, 0xAAAA) on the same edge.
  - Required: ready drops at that edge and returns 8 edges later. addr 2 reads 0x0000, and addr 3 (previously 0xBEEF) reads 0x0000.
- **Writes ignored during INIT:**
  - Stimulus: pulse load with 0x5555 to addr 0 while ready=0.
  - Required: after ready rises, addr 0 reads 0x0000.
- **rst mid-sweep:**
  - Stimulus: assert rst at sweep edge 4, then release.
  - Required: ready stays 0 for a full 8 edges after release, then all words read 0.
- **Parameter corner, WIDTH=1, DEPTH=2:**
  - Required: sweep is 2 edges. Writing 1 to addr 1 reads back 1, and addr 0 reads 0.
